list_prefetch_cache: RTL

//  Parametrised prefetching argument cache between the HP-port list stream and a consumer IP.
//  - On START, fetches LIST_LEN elements from LIST_IN into a DEPTH-entry ring buffer.
//  - Presents them in order on ARG_OUT under a valid/ready handshake.
//  - Flags the final element and pulses DONE when the list is fully delivered.

---
 rtl/list_prefetch_cache.sv | 118 +++++++++++
 1 files changed

// File: rtl/list_prefetch_cache.sv
// Prefetching argument cache: streams a list into a small ring buffer and
// hands the elements, in order, to a consumer over a valid/ready handshake.
module list_prefetch_cache #(
   parameter int TYPE_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  listLen_i,
   input  logic [TYPE_WIDTH-1:0] listIn_i,
   input  logic                  listValid_i,
   output logic                  next_o,
   input  logic                  ready_i,
   output logic [TYPE_WIDTH-1:0] argOut_o,
   output logic                  argValid_o,
   output logic                  argLast_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wrPtr_q, wrPtr_d;
   logic [PW-1:0]         rdPtr_q, rdPtr_d;
   logic [PW:0]           count_q, count_d;
   logic [LEN_WIDTH-1:0]  fetchRem_q, fetchRem_d;
   logic [LEN_WIDTH-1:0]  deliverRem_q, deliverRem_d;
   logic                  zeroDone_q, zeroDone_d;
   logic [TYPE_WIDTH-1:0] mem [DEPTH];
   logic                  push;
   logic                  pop;

   // All outputs come from registers only, so the consumer never sees a combinational path from READY.
   assign next_o     = (state_q == RUN) && (fetchRem_q != '0) && (count_q != FULL_COUNT);
   assign argValid_o = (count_q != '0);
   assign argOut_o   = argValid_o ? mem[rdPtr_q] : '0;
   assign argLast_o  = argValid_o && (deliverRem_q == LEN_WIDTH'(1));
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == FIN) || zeroDone_q;
   assign push       = next_o && listValid_i;
   assign pop        = argValid_o && ready_i;

   always_comb begin
      state_d      = state_q;
      wrPtr_d      = wrPtr_q;
      rdPtr_d      = rdPtr_q;
      count_d      = count_q;
      fetchRem_d   = fetchRem_q;
      deliverRem_d = deliverRem_q;
      zeroDone_d   = 1'b0;

      if (push) begin
         wrPtr_d    = wrPtr_q + PW'(1);
         fetchRem_d = fetchRem_q - LEN_WIDTH'(1);
      end
      if (pop) begin
         rdPtr_d      = rdPtr_q + PW'(1);
         deliverRem_d = deliverRem_q - LEN_WIDTH'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase

      // A zero-length list never enters RUN; it only produces the DONE pulse.
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (listLen_i != '0) begin
                  state_d      = RUN;
                  fetchRem_d   = listLen_i;
                  deliverRem_d = listLen_i;
               end else begin
                  zeroDone_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (pop && (deliverRem_q == LEN_WIDTH'(1))) state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         fetchRem_q   <= '0;
         deliverRem_q <= '0;
         zeroDone_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         fetchRem_q   <= fetchRem_d;
         deliverRem_q <= deliverRem_d;
         zeroDone_q   <= zeroDone_d;
      end
   end

   // Buffer storage carries no reset; stale contents are masked by count.
   always_ff @(posedge clk_i) begin
      if (push) mem[wrPtr_q] <= listIn_i;
   end

endmodule
